// File: rtl/mp_add_seq.sv
// rtl/mp_add_seq.sv - multi-precision add/subtract sequencer, one 16-bit limb per cycle
module clax16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c_in,
  output logic [15:0] sum,
  output logic        g_out,
  output logic        p_out
);
  logic [15:0] g, p, c;
  logic [3:0]  gg, gp;
  logic [4:0]  gc;

  // Two-level lookahead: bit carries within each nibble, nibble carries across the word.
  function automatic logic [3:0] nib_carry(input logic [3:0] gn, input logic [3:0] pn, input logic ci);
    nib_carry[0] = ci;
    nib_carry[1] = gn[0] | (pn[0] & ci);
    nib_carry[2] = gn[1] | (pn[1] & gn[0]) | (pn[1] & pn[0] & ci);
    nib_carry[3] = gn[2] | (pn[2] & gn[1]) | (pn[2] & pn[1] & gn[0]) | (pn[2] & pn[1] & pn[0] & ci);
  endfunction

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      gg[i] = g[4*i+3] | (p[4*i+3] & g[4*i+2]) | (p[4*i+3] & p[4*i+2] & g[4*i+1])
            | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
      gp[i] = &p[4*i +: 4];
    end
  end

  assign gc[0] = c_in;
  assign gc[1] = gg[0] | (gp[0] & c_in);
  assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c_in);
  assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & c_in);
  assign gc[4] = g_out | (p_out & c_in);

  assign g_out = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0]);
  assign p_out = &gp;

  assign c[3:0]   = nib_carry(g[3:0],   p[3:0],   gc[0]);
  assign c[7:4]   = nib_carry(g[7:4],   p[7:4],   gc[1]);
  assign c[11:8]  = nib_carry(g[11:8],  p[11:8],  gc[2]);
  assign c[15:12] = nib_carry(g[15:12], p[15:12], gc[3]);

  assign sum = p ^ c;
endmodule

module mp_add_seq #(
  parameter int WORDS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                sub,
  input  logic [16*WORDS-1:0] a,
  input  logic [16*WORDS-1:0] b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [16*WORDS-1:0] s,
  output logic                c_out,
  output logic                ovf
);
  localparam int W  = 16 * WORDS;
  localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [W-1:0]  a_q, b_q;
  logic [CW-1:0] cnt;
  logic          carry;
  logic [15:0]   a_limb, b_limb, sum;
  logic          g_o, p_o, carry_nxt, last;

  assign a_limb    = a_q[cnt*16 +: 16];
  assign b_limb    = b_q[cnt*16 +: 16];
  assign carry_nxt = g_o | (p_o & carry);
  assign last      = (cnt == CW'(WORDS - 1));

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  clax16 u_cla (
    .a     (a_limb),
    .b     (b_limb),
    .c_in  (carry),
    .sum   (sum),
    .g_out (g_o),
    .p_out (p_o)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      s     <= '0;
      c_out <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
            a_q   <= a;
            b_q   <= b ^ {W{sub}};
            carry <= sub;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          s[cnt*16 +: 16] <= sum;
          carry           <= carry_nxt;
          cnt             <= cnt + 1'b1;
          if (last) begin
            c_out <= carry_nxt;
            ovf   <= (a_limb[15] == b_limb[15]) && (sum[15] != a_limb[15]);
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mp_add_seq.sv
// tb/tb_mp_add_seq.sv - scoreboard bench for mp_add_seq
module tb_mp_add_seq;
  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } res_t;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, sub, out_valid, out_ready, c_out, ovf;
  logic [W-1:0] a, b, s;

  res_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mp_add_seq #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sub       (sub),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .c_out     (c_out),
    .ovf       (ovf)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic res_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sb);
    logic [W-1:0] bb;
    logic [W:0]   full;
    res_t         r;
    bb   = sb ? ~bv : bv;
    full = {1'b0, av} + {1'b0, bb} + {{W{1'b0}}, sb};
    r.s  = full[W-1:0];
    r.c  = full[W];
    r.v  = (av[W-1] == bb[W-1]) && (full[W-1] != av[W-1]);
    return r;
  endfunction

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] v;
    for (int k = 0; k < WORDS; k++) v[k*16 +: 16] = 16'($urandom);
    return v;
  endfunction

  task automatic push(input logic [W-1:0] es, input logic ec, input logic ev);
    res_t r;
    r.s = es; r.c = ec; r.v = ev;
    exp_q.push_back(r);
  endtask

  // Returns #1 after the accepting clock edge.
  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sb);
    int n;
    a = av; b = bv; sub = sb; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("accept_ready", 128'(in_ready), 128'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = rand_w(); b = rand_w(); sub = 1'($urandom);
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    chk("out_valid_seen", 128'(out_valid), 128'(1));
  endtask

  task automatic compare_result(input string tag);
    res_t r;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_nonempty"}, 128'(0), 128'(1));
    end else begin
      r = exp_q.pop_front();
      chk({tag, "_s"},     128'(s),     128'(r.s));
      chk({tag, "_c_out"}, 128'(c_out), 128'(r.c));
      chk({tag, "_ovf"},   128'(ovf),   128'(r.v));
    end
  endtask

  task automatic release_result(input int stall);
    repeat (stall) begin
      out_ready = 1'b0; @(posedge clk); #1;
    end
    out_ready = 1'b1; @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv, input logic sb,
                        input int stall);
    int lat;
    send(av, bv, sb);
    wait_valid(lat);
    compare_result(tag);
    release_result(stall);
  endtask

  initial begin
    int           lat;
    logic [W-1:0] ones, one, smax, smin, s_hold;
    logic         c_hold, v_hold;
    ones = '1;
    one  = W'(1);
    smax = {1'b0, {(W-1){1'b1}}};
    smin = {1'b1, {(W-1){1'b0}}};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  128'(in_ready),  128'(1));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_s",         128'(s),         128'(0));
    chk("rst_c_out",     128'(c_out),     128'(0));
    chk("rst_ovf",       128'(ovf),       128'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // Carry ripples out of limb 0, plus latency from the accepting edge.
    push(W'(32'h0001_0000), 1'b0, 1'b0);
    send(W'(16'hFFFF), one, 1'b0);
    wait_valid(lat);
    chk("latency", 128'(lat), 128'(WORDS + 1));
    compare_result("ripple");
    release_result(0);

    push('0, 1'b1, 1'b0);
    run_op("wrap", ones, one, 1'b0, 1);
    push(smin, 1'b0, 1'b1);
    run_op("signed_ovf", smax, one, 1'b0, 0);
    push(W'(16'hFFFF), 1'b1, 1'b0);
    run_op("sub_borrow", W'(32'h0001_0000), one, 1'b1, 2);
    push(ones, 1'b0, 1'b0);
    run_op("zero_minus_one", '0, one, 1'b1, 0);

    // Backpressure with a second request held by the master throughout.
    push(W'(8), 1'b0, 1'b0);
    send(W'(5), W'(3), 1'b0);
    a = W'(3); b = W'(5); sub = 1'b1; in_valid = 1'b1;
    wait_valid(lat);
    s_hold = s; c_hold = c_out; v_hold = ovf;
    compare_result("bp_first");
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_stable_s",   128'(s),         128'(s_hold));
      chk("bp_stable_c",   128'(c_out),     128'(c_hold));
      chk("bp_stable_v",   128'(ovf),       128'(v_hold));
      chk("bp_in_ready",   128'(in_ready),  128'(0));
      chk("bp_out_valid",  128'(out_valid), 128'(1));
    end
    out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
    chk("bp_idle_ready", 128'(in_ready),  128'(1));
    chk("bp_idle_valid", 128'(out_valid), 128'(0));
    push({{(W-1){1'b1}}, 1'b0}, 1'b0, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_second_taken", 128'(in_ready), 128'(0));
    wait_valid(lat);
    compare_result("bp_second");
    release_result(0);

    // Asynchronous reset while limb 2 is being processed.
    send(ones, ones, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_out_valid", 128'(out_valid), 128'(0));
    chk("rst_mid_s",         128'(s),         128'(0));
    chk("rst_mid_in_ready",  128'(in_ready),  128'(1));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    push(W'(16'h5555), 1'b0, 1'b0);
    run_op("after_rst", W'(16'h1234), W'(16'h4321), 1'b0, 0);

    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] ra, rb;
      logic         rs;
      ra = rand_w(); rb = rand_w(); rs = 1'($urandom);
      if (i % 50 == 0) ra = ones;
      if (i % 50 == 1) rb = smin;
      exp_q.push_back(model(ra, rb, rs));
      run_op("rand", ra, rb, rs, int'($urandom_range(0, 3)));
    end
    chk("queue_drained", 128'(exp_q.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
